// File: rtl/controlador_contagem.sv
`default_nettype none
// ============================================================================
// Module   : controlador_contagem
// Brief    : Phase sequencer for the 4-bit up/down counter. Holds a table of
//            counting phases (terminal value, direction, repeat count) and
//            drives the counter's max_value / decrescente / clear inputs,
//            advancing phases by counting the counter's wrap pulses.
// Revision : 1.0 - initial release
// ============================================================================
module controlador_contagem #(
    parameter int N_FASES = 4,
    parameter int REP_W   = 3,
    localparam int IDX_W  = $clog2(N_FASES)
) (
    input  logic             clk,
    input  logic             resetar_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [3:0]       cfg_max,
    input  logic             cfg_dec,
    input  logic [REP_W-1:0] cfg_rep,
    input  logic             iniciar,
    input  logic [IDX_W-1:0] ultima_fase,
    input  logic             ciclico,
    input  logic             parar,
    input  logic             cnt_wrap,
    output logic [3:0]       cnt_max,
    output logic             cnt_dec,
    output logic             cnt_clr,
    output logic [IDX_W-1:0] fase,
    output logic [REP_W-1:0] rep_restantes,
    output logic             ocupado,
    output logic             concluido
);

    localparam int unsigned c_ULT_MAX = N_FASES - 1;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        PREPARA = 2'd1,
        CONTA   = 2'd2,
        FIM     = 2'd3
    } t_estado;

    t_estado          r_estado;
    t_estado          w_estado_prox;
    logic             r_cnt_clr;

    logic [3:0]       r_tab_max [N_FASES];
    logic             r_tab_dec [N_FASES];
    logic [REP_W-1:0] r_tab_rep [N_FASES];

    logic [IDX_W-1:0] r_fase;
    logic [IDX_W-1:0] r_ultima;
    logic [REP_W-1:0] r_rep;
    logic             r_descarta;

    logic [IDX_W-1:0] w_fase_prox;
    logic [IDX_W-1:0] w_ult_prox;
    logic [REP_W-1:0] w_rep_prox;
    logic             w_desc_prox;
    logic [IDX_W-1:0] w_fase_seg;
    logic [IDX_W-1:0] w_ult_sat;
    logic             w_escreve;
    logic [REP_W-1:0] w_rep0;
    logic             w_dec0;

    // Table writes are only accepted while idle.
    assign w_escreve = cfg_valid && (r_estado == OCIOSO);

    // A write to entry 0 on the start edge must be seen by the first phase.
    assign w_rep0 = (w_escreve && (cfg_idx == '0)) ? cfg_rep : r_tab_rep[0];
    assign w_dec0 = (w_escreve && (cfg_idx == '0)) ? cfg_dec : r_tab_dec[0];

    // Out-of-range last-phase requests clamp to the final table entry.
    assign w_ult_sat = (32'(ultima_fase) > c_ULT_MAX) ? IDX_W'(c_ULT_MAX) : ultima_fase;

    // Phase that follows the current one (wraps to 0 after the last).
    assign w_fase_seg = (r_fase < r_ultima) ? r_fase + IDX_W'(1) : '0;

    // Next-state and phase bookkeeping; abort overrides everything else.
    always_comb begin
        w_estado_prox = r_estado;
        w_fase_prox   = r_fase;
        w_ult_prox    = r_ultima;
        w_rep_prox    = r_rep;
        w_desc_prox   = r_descarta;
        case (r_estado)
            OCIOSO: begin
                if (iniciar) begin
                    w_estado_prox = PREPARA;
                    w_fase_prox   = '0;
                    w_ult_prox    = w_ult_sat;
                    w_rep_prox    = w_rep0;
                    w_desc_prox   = w_dec0;
                end
            end
            PREPARA: w_estado_prox = CONTA;
            CONTA: begin
                if (cnt_wrap) begin
                    if (r_descarta) begin
                        // Priming wrap of a down phase is not a real period.
                        w_desc_prox = 1'b0;
                    end else if (r_rep != '0) begin
                        w_rep_prox = r_rep - REP_W'(1);
                    end else if ((r_fase < r_ultima) || ciclico) begin
                        w_estado_prox = PREPARA;
                        w_fase_prox   = w_fase_seg;
                        w_rep_prox    = r_tab_rep[w_fase_seg];
                        w_desc_prox   = r_tab_dec[w_fase_seg];
                    end else begin
                        w_estado_prox = FIM;
                    end
                end
            end
            FIM:     w_estado_prox = OCIOSO;
            default: w_estado_prox = OCIOSO;
        endcase
        if (parar && (r_estado != OCIOSO)) begin
            w_estado_prox = OCIOSO;
        end
    end

    // State register; the counter clear is held everywhere except CONTA.
    always_ff @(posedge clk or negedge resetar_n) begin
        if (!resetar_n) begin
            r_estado  <= OCIOSO;
            r_cnt_clr <= 1'b1;
        end else begin
            r_estado  <= w_estado_prox;
            r_cnt_clr <= (w_estado_prox != CONTA);
        end
    end

    // Phase index, latched last phase, remaining repeats and discard flag.
    always_ff @(posedge clk or negedge resetar_n) begin
        if (!resetar_n) begin
            r_fase     <= '0;
            r_ultima   <= '0;
            r_rep      <= '0;
            r_descarta <= 1'b0;
        end else begin
            r_fase     <= w_fase_prox;
            r_ultima   <= w_ult_prox;
            r_rep      <= w_rep_prox;
            r_descarta <= w_desc_prox;
        end
    end

    // Phase table storage, cleared on reset.
    always_ff @(posedge clk or negedge resetar_n) begin
        if (!resetar_n) begin
            for (int i = 0; i < N_FASES; i++) begin
                r_tab_max[i] <= '0;
                r_tab_dec[i] <= 1'b0;
                r_tab_rep[i] <= '0;
            end
        end else if (w_escreve) begin
            r_tab_max[cfg_idx] <= cfg_max;
            r_tab_dec[cfg_idx] <= cfg_dec;
            r_tab_rep[cfg_idx] <= cfg_rep;
        end
    end

    assign cfg_ready     = (r_estado == OCIOSO);
    assign ocupado       = (r_estado != OCIOSO);
    assign concluido     = (r_estado == FIM);
    assign cnt_clr       = r_cnt_clr;
    assign cnt_max       = (r_estado == OCIOSO) ? 4'd0 : r_tab_max[r_fase];
    assign cnt_dec       = (r_estado == OCIOSO) ? 1'b0 : r_tab_dec[r_fase];
    assign fase          = r_fase;
    assign rep_restantes = r_rep;

endmodule
`default_nettype wire

// File: tb/tb_controlador_contagem.sv
`default_nettype none
// ============================================================================
// Module   : tb_controlador_contagem
// Brief    : Self-checking bench for controlador_contagem with a behavioural
//            4-bit up/down counter attached and a phase-schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controlador_contagem;

    logic       clk = 1'b0;
    logic       resetar_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_max;
    logic       cfg_dec;
    logic [2:0] cfg_rep;
    logic       iniciar;
    logic [1:0] ultima_fase;
    logic       ciclico;
    logic       parar;
    logic       cnt_wrap;
    logic [3:0] cnt_max;
    logic       cnt_dec;
    logic       cnt_clr;
    logic [1:0] fase;
    logic [2:0] rep_restantes;
    logic       ocupado;
    logic       concluido;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the phase table as it should be inside the DUT.
    int m_max [4];
    int m_dec [4];
    int m_rep [4];

    controlador_contagem dut (
        .clk           (clk),
        .resetar_n     (resetar_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_idx       (cfg_idx),
        .cfg_max       (cfg_max),
        .cfg_dec       (cfg_dec),
        .cfg_rep       (cfg_rep),
        .iniciar       (iniciar),
        .ultima_fase   (ultima_fase),
        .ciclico       (ciclico),
        .parar         (parar),
        .cnt_wrap      (cnt_wrap),
        .cnt_max       (cnt_max),
        .cnt_dec       (cnt_dec),
        .cnt_clr       (cnt_clr),
        .fase          (fase),
        .rep_restantes (rep_restantes),
        .ocupado       (ocupado),
        .concluido     (concluido)
    );

    always #5 clk = ~clk;

    // Behavioural 4-bit up/down counter with registered wrap.
    logic [3:0] r_cnt;
    always @(posedge clk or negedge resetar_n) begin
        if (!resetar_n) begin
            r_cnt    <= 4'd0;
            cnt_wrap <= 1'b0;
        end else if (cnt_clr) begin
            r_cnt    <= 4'd0;
            cnt_wrap <= 1'b0;
        end else if (!cnt_dec) begin
            if (r_cnt == cnt_max) begin
                r_cnt    <= 4'd0;
                cnt_wrap <= 1'b1;
            end else begin
                r_cnt    <= r_cnt + 4'd1;
                cnt_wrap <= 1'b0;
            end
        end else begin
            if (r_cnt == 4'd0) begin
                r_cnt    <= cnt_max;
                cnt_wrap <= 1'b1;
            end else begin
                r_cnt    <= r_cnt - 4'd1;
                cnt_wrap <= 1'b0;
            end
        end
    end

    logic [8:0] obs_ctrl;
    logic [4:0] obs_st;
    assign obs_ctrl = {cnt_max, cnt_dec, cnt_clr, ocupado, concluido, cfg_ready};
    assign obs_st   = {fase, rep_restantes};

    function automatic logic [8:0] ectrl(int mx, int d, int clr, int oc, int cc, int rd);
        return {4'(mx), 1'(d), 1'(clr), 1'(oc), 1'(cc), 1'(rd)};
    endfunction

    function automatic logic [4:0] est(int f, int r);
        return {2'(f), 3'(r)};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 4; i++) begin
            m_max[i] = 0;
            m_dec[i] = 0;
            m_rep[i] = 0;
        end
    endtask

    task automatic wr(int idx, int mx, int d, int r);
        cfg_valid = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_max   = 4'(mx);
        cfg_dec   = 1'(d);
        cfg_rep   = 3'(r);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        m_max[idx] = mx;
        m_dec[idx] = d;
        m_rep[idx] = r;
    endtask

    // One run: phases 0..ult repeated 'passes' times, optional abort at
    // cycle abort_at, optional write to entry 0 on the start edge, optional
    // random write attempts while busy (which must be ignored).
    task automatic run(string nm, int ult, int passes, int abort_at,
                       bit swr, int sm, int sd, int sr, bit busy_wr);
        int seq[$];
        int st[$];
        int s_end, lp_start, t, k, f, o, mx, d, r, first, cnt;
        if (swr) begin
            m_max[0] = sm;
            m_dec[0] = sd;
            m_rep[0] = sr;
        end
        // Each phase: 1 PREPARA + 1 CONTA setup cycle + (R+1)(M+1) counting
        // cycles, plus the discarded priming wrap for down phases.
        t = 0;
        for (int p = 0; p < passes; p++) begin
            for (int q = 0; q <= ult; q++) begin
                seq.push_back(q);
                st.push_back(t);
                t += 2 + (m_rep[q] + 1) * (m_max[q] + 1) + m_dec[q];
            end
        end
        s_end    = t;
        lp_start = st[(passes - 1) * (ult + 1)];

        iniciar     = 1'b1;
        ultima_fase = 2'(ult);
        ciclico     = (passes > 1);
        cfg_valid   = swr;
        cfg_idx     = 2'd0;
        cfg_max     = 4'(sm);
        cfg_dec     = 1'(sd);
        cfg_rep     = 3'(sr);
        @(posedge clk);
        #1;
        iniciar   = 1'b0;
        cfg_valid = 1'b0;

        for (int c = 0; c <= s_end + 1; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            ciclico   = (c + 1 <= lp_start);
            parar     = (c + 1 == abort_at);
            cfg_valid = busy_wr && (c + 1 <= s_end) && ($urandom_range(0, 1) == 1);
            cfg_idx   = 2'($urandom_range(0, 3));
            cfg_max   = 4'($urandom_range(0, 15));
            cfg_dec   = 1'($urandom_range(0, 1));
            cfg_rep   = 3'($urandom_range(0, 7));

            if ((abort_at >= 0 && c >= abort_at) || c > s_end) begin
                chk($sformatf("%s c%0d idle", nm, c), 32'(obs_ctrl), 32'(ectrl(0, 0, 1, 0, 0, 1)));
                if (c >= abort_at) break;
            end else if (c == s_end) begin
                f = seq[seq.size() - 1];
                chk($sformatf("%s c%0d fim", nm, c), 32'(obs_ctrl),
                    32'(ectrl(m_max[f], m_dec[f], 1, 1, 1, 0)));
                chk($sformatf("%s c%0d fim_st", nm, c), 32'(obs_st), 32'(est(f, 0)));
            end else begin
                k = 0;
                for (int i = 0; i < st.size(); i++) if (st[i] <= c) k = i;
                f  = seq[k];
                o  = c - st[k];
                mx = m_max[f];
                d  = m_dec[f];
                r  = m_rep[f];
                // Counted wraps are seen at offsets first, first+(M+1), ...
                first = 3 + mx + d;
                cnt   = (o < first) ? 0 : (o - first) / (mx + 1) + 1;
                chk($sformatf("%s c%0d ctrl", nm, c), 32'(obs_ctrl),
                    32'(ectrl(mx, d, (o == 0) ? 1 : 0, 1, 0, 0)));
                chk($sformatf("%s c%0d st", nm, c), 32'(obs_st), 32'(est(f, r - cnt)));
            end
        end
        parar     = 1'b0;
        cfg_valid = 1'b0;
        ciclico   = 1'b0;
    endtask

    initial begin
        resetar_n   = 1'b0;
        cfg_valid   = 1'b0;
        cfg_idx     = 2'd0;
        cfg_max     = 4'd0;
        cfg_dec     = 1'b0;
        cfg_rep     = 3'd0;
        iniciar     = 1'b0;
        ultima_fase = 2'd0;
        ciclico     = 1'b0;
        parar       = 1'b0;
        mdl_clear();

        repeat (2) @(posedge clk);
        #1;
        chk("reset ctrl", 32'(obs_ctrl), 32'(ectrl(0, 0, 1, 0, 0, 1)));
        chk("reset st", 32'(obs_st), 32'(est(0, 0)));
        resetar_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle ctrl", 32'(obs_ctrl), 32'(ectrl(0, 0, 1, 0, 0, 1)));

        wr(0, 3, 0, 1);
        run("up31", 0, 1, -1, 0, 0, 0, 0, 0);

        wr(0, 2, 0, 0);
        wr(1, 2, 1, 0);
        run("updown", 1, 1, -1, 0, 0, 0, 0, 0);

        wr(0, 1, 0, 0);
        run("ciclo", 0, 3, -1, 0, 0, 0, 0, 0);

        // Abort coincides with the final counted wrap (phase length 8).
        wr(0, 2, 0, 1);
        run("parar_fim", 0, 1, 8, 0, 0, 0, 0, 0);

        run("busy_wr", 0, 1, -1, 0, 0, 0, 0, 1);
        run("busy_chk", 0, 1, -1, 0, 0, 0, 0, 0);

        run("wr_start", 0, 1, -1, 1, 9, 0, 0, 0);

        wr(0, 0, 0, 7);
        run("m0r7", 0, 1, -1, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a down phase.
        wr(0, 4, 1, 2);
        iniciar     = 1'b1;
        ultima_fase = 2'd0;
        @(posedge clk);
        #1;
        iniciar = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        resetar_n = 1'b0;
        #1;
        chk("arst ctrl", 32'(obs_ctrl), 32'(ectrl(0, 0, 1, 0, 0, 1)));
        chk("arst st", 32'(obs_st), 32'(est(0, 0)));
        @(posedge clk);
        #1;
        resetar_n = 1'b1;
        mdl_clear();
        run("pos_rst", 0, 1, -1, 0, 0, 0, 0, 0);

        for (int it = 0; it < 8; it++) begin
            for (int e = 0; e < 4; e++) begin
                wr(e, int'($urandom_range(0, 4)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 2)));
            end
            run($sformatf("rnd%0d", it), int'($urandom_range(0, 3)), int'($urandom_range(1, 2)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1,
                1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
